softmax_1: RTL and testbench

- Computes softmax over 10 IEEE-754 single-precision values: out[i] = exp(x[i]) / Σ exp(x[j]).
- Final classification stage of the CNN datapath, after the last fully-connected layer.
- Multi-cycle, sequential FP datapath started by a level enable; completion is flagged by ackSoft.

---
 rtl/softmax_1_pkg.sv | 38 +++
 rtl/fp_units.sv | 123 ++++++++++++
 rtl/softmax_1_exp.sv | 37 +++
 rtl/softmax_1.sv | 135 +++++++++++++
 tb/tb_softmax_1.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/softmax_1_pkg.sv
// Shared constants for the softmax datapath: binary32 literals, the Taylor
// reciprocal ROM and the controller state encoding.
package softmax_1_pkg;

   localparam logic [31:0] FP_ONE  = 32'h3F800000;
   localparam logic [31:0] FP_ZERO = 32'h00000000;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_EXP,
      ST_DIV,
      ST_DONE
   } state_t;

   // 1/k in binary32, round-to-nearest-even; k = 0 is never consumed
   function automatic logic [31:0] recip_rom(input logic [3:0] k);
      logic [31:0] r;
      case (k)
         4'd2:    r = 32'h3F000000;
         4'd3:    r = 32'h3EAAAAAB;
         4'd4:    r = 32'h3E800000;
         4'd5:    r = 32'h3E4CCCCD;
         4'd6:    r = 32'h3E2AAAAB;
         4'd7:    r = 32'h3E124925;
         4'd8:    r = 32'h3E000000;
         4'd9:    r = 32'h3DE38E39;
         4'd10:   r = 32'h3DCCCCCD;
         4'd11:   r = 32'h3DBA2E8C;
         4'd12:   r = 32'h3DAAAAAB;
         4'd13:   r = 32'h3D9D89D9;
         4'd14:   r = 32'h3D924925;
         4'd15:   r = 32'h3D888889;
         default: r = FP_ONE;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/fp_units.sv
// Combinational binary32 add, multiply and divide; round-to-nearest-even,
// denormal operands and results flushed to zero, NaN/Inf not handled.
module fp_add (
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] y
);
   logic [31:0]        big, sml;
   logic [7:0]         d;
   logic [26:0]        ms, sh, n;
   logic [27:0]        s;
   logic [23:0]        m;
   logic               st, up;
   logic signed [10:0] e;

   always_comb begin
      if (a[30:0] >= b[30:0]) begin
         big = a;
         sml = b;
      end else begin
         big = b;
         sml = a;
      end
      d  = big[30:23] - sml[30:23];
      ms = {1'b1, sml[22:0], 3'b000};
      st = 1'b0;
      for (int unsigned i = 0; i < 27; i++)
         if (i < 32'(d) && ms[i]) st = 1'b1;
      sh    = (d >= 8'd27) ? '0 : (ms >> d);
      sh[0] = sh[0] | st;
      e     = $signed({3'b000, big[30:23]});
      if (big[31] == sml[31]) begin
         s = {2'b01, big[22:0], 3'b000} + {1'b0, sh};
         if (s[27]) begin
            n = {s[27:2], s[1] | s[0]};
            e = e + 11'sd1;
         end else begin
            n = s[26:0];
         end
      end else begin
         s = {2'b01, big[22:0], 3'b000} - {1'b0, sh};
         n = s[26:0];
         for (int unsigned i = 0; i < 26; i++)
            if (n != '0 && !n[26]) begin
               n = n << 1;
               e = e - 11'sd1;
            end
      end
      up = n[2] & (n[1] | n[0] | n[3]);
      m  = {1'b0, n[25:3]} + {23'b0, up};
      if (m[23]) e = e + 11'sd1;
      if (big[30:23] == 8'd0)       y = '0;
      else if (sml[30:23] == 8'd0)  y = big;
      else if (n == '0)             y = '0;
      else if (e <= 11'sd0)         y = {big[31], 31'b0};
      else if (e >= 11'sd255)       y = {big[31], 8'hFF, 23'b0};
      else                          y = {big[31], e[7:0], m[22:0]};
   end
endmodule

module fp_mul (
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] y
);
   logic [47:0]        p;
   logic [23:0]        m;
   logic               s, up;
   logic signed [10:0] e;

   always_comb begin
      s = a[31] ^ b[31];
      p = {1'b1, a[22:0]} * {1'b1, b[22:0]};
      e = $signed({3'b000, a[30:23]}) + $signed({3'b000, b[30:23]}) - 11'sd127;
      if (p[47]) e = e + 11'sd1;
      else       p = p << 1;
      up = p[23] & ((|p[22:0]) | p[24]);
      m  = {1'b0, p[46:24]} + {23'b0, up};
      if (m[23]) e = e + 11'sd1;
      if (a[30:23] == 8'd0 || b[30:23] == 8'd0 || e <= 11'sd0) y = {s, 31'b0};
      else if (e >= 11'sd255)                                   y = {s, 8'hFF, 23'b0};
      else                                                      y = {s, e[7:0], m[22:0]};
   end
endmodule

module fp_div (
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] y
);
   logic [49:0]        num;
   logic [26:0]        q;
   logic [23:0]        r;
   logic [22:0]        mt;
   logic [23:0]        m;
   logic               s, g, st, up;
   logic signed [10:0] e;

   always_comb begin
      s   = a[31] ^ b[31];
      num = {1'b1, a[22:0], 26'b0};
      // quotient lands in [2^25, 2^27): one normalisation step at most
      q   = 27'(num / {26'b0, 1'b1, b[22:0]});
      r   = 24'(num % {26'b0, 1'b1, b[22:0]});
      e   = $signed({3'b000, a[30:23]}) - $signed({3'b000, b[30:23]}) + 11'sd127;
      if (q[26]) begin
         mt = q[25:3];
         g  = q[2];
         st = q[1] | q[0] | (r != '0);
      end else begin
         mt = q[24:2];
         g  = q[1];
         st = q[0] | (r != '0);
         e  = e - 11'sd1;
      end
      up = g & (st | mt[0]);
      m  = {1'b0, mt} + {23'b0, up};
      if (m[23]) e = e + 11'sd1;
      if (a[30:23] == 8'd0 || e <= 11'sd0)         y = {s, 31'b0};
      else if (b[30:23] == 8'd0 || e >= 11'sd255)  y = {s, 8'hFF, 23'b0};
      else                                         y = {s, e[7:0], m[22:0]};
   end
endmodule

// File: rtl/softmax_1_exp.sv
// Iterative Taylor-series exp: one term per step, term/acc restart at k = 1.
module softmax_exp
   import softmax_1_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] x,
   input  logic [3:0]  k,
   input  logic        step,
   output logic [31:0] acc
);
   logic [31:0] term_q, term_d, acc_q, acc_d;
   logic [31:0] term_in, acc_in, xt, term_new, acc_new;

   always_comb begin
      term_in = (k == 4'd1) ? FP_ONE : term_q;
      acc_in  = (k == 4'd1) ? FP_ONE : acc_q;
      term_d  = step ? term_new : term_q;
      acc_d   = step ? acc_new : acc_q;
   end

   fp_mul u_mul_x (.a(term_in), .b(x),            .y(xt));
   fp_mul u_mul_r (.a(xt),      .b(recip_rom(k)), .y(term_new));
   fp_add u_add   (.a(acc_in),  .b(term_new),     .y(acc_new));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         term_q <= '0;
         acc_q  <= '0;
      end else begin
         term_q <= term_d;
         acc_q  <= acc_d;
      end
   end

   assign acc = acc_q;
endmodule

// File: rtl/softmax_1.sv
// Sequential softmax over inputNum binary32 values: Taylor exp per element,
// running sum, then one division per cycle; ackSoft flags a completed run.
module softmax_1
   import softmax_1_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned inputNum   = 10,
   parameter int unsigned EXP_TERMS  = 16
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [DATA_WIDTH*inputNum-1:0] inputs,
   input  logic                           enable,
   output logic [DATA_WIDTH*inputNum-1:0] outputs,
   output logic                           ackSoft
);
   localparam int unsigned IDX_W = $clog2(inputNum);
   localparam int unsigned CNT_W = $clog2(EXP_TERMS);

   state_t                         state_q, state_d;
   logic [DATA_WIDTH-1:0]          x_q  [inputNum];
   logic [DATA_WIDTH-1:0]          x_d  [inputNum];
   logic [DATA_WIDTH-1:0]          ex_q [inputNum];
   logic [DATA_WIDTH-1:0]          ex_d [inputNum];
   logic [DATA_WIDTH-1:0]          sum_q, sum_d;
   logic [DATA_WIDTH*inputNum-1:0] out_q, out_d;
   logic [IDX_W-1:0]               idx_q, idx_d;
   logic [CNT_W-1:0]               cnt_q, cnt_d;
   logic                           ack_q, ack_d;
   logic [DATA_WIDTH-1:0]          x_sel, ex_sel, exp_val, sum_new, quot;
   logic [3:0]                     k;
   logic                           step;

   assign k = 4'(cnt_q) + 4'd1;

   softmax_exp u_exp (
      .clk   (clk),
      .rst_n (reset),
      .x     (x_sel),
      .k     (k),
      .step  (step),
      .acc   (exp_val)
   );

   fp_add u_sum (.a(sum_q),  .b(exp_val), .y(sum_new));
   fp_div u_div (.a(ex_sel), .b(sum_q),   .y(quot));

   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      ex_d    = ex_q;
      sum_d   = sum_q;
      out_d   = out_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      ack_d   = 1'b0;
      step    = 1'b0;
      x_sel   = '0;
      ex_sel  = '0;
      for (int unsigned i = 0; i < inputNum; i++)
         if (idx_q == IDX_W'(i)) begin
            x_sel  = x_q[i];
            ex_sel = ex_q[i];
         end
      if (!enable) begin
         state_d = ST_IDLE;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
               for (int unsigned i = 0; i < inputNum; i++)
                  x_d[i] = inputs[DATA_WIDTH*(inputNum-i)-1 -: DATA_WIDTH];
               sum_d   = FP_ZERO;
               idx_d   = '0;
               cnt_d   = '0;
               state_d = ST_EXP;
            end
            ST_EXP: begin
               // counts 0..EXP_TERMS-2 iterate, the last count stores exp and accumulates
               if (cnt_q != CNT_W'(EXP_TERMS-1)) begin
                  step  = 1'b1;
                  cnt_d = cnt_q + CNT_W'(1);
               end else begin
                  for (int unsigned i = 0; i < inputNum; i++)
                     if (idx_q == IDX_W'(i)) ex_d[i] = exp_val;
                  sum_d = sum_new;
                  cnt_d = '0;
                  if (idx_q == IDX_W'(inputNum-1)) begin
                     idx_d   = '0;
                     state_d = ST_DIV;
                  end else begin
                     idx_d = idx_q + IDX_W'(1);
                  end
               end
            end
            ST_DIV: begin
               for (int unsigned i = 0; i < inputNum; i++)
                  if (idx_q == IDX_W'(i)) out_d[DATA_WIDTH*(inputNum-i)-1 -: DATA_WIDTH] = quot;
               if (idx_q == IDX_W'(inputNum-1)) begin
                  idx_d   = '0;
                  state_d = ST_DONE;
               end else begin
                  idx_d = idx_q + IDX_W'(1);
               end
            end
            ST_DONE: ack_d = 1'b1;
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         x_q     <= '{default: '0};
         ex_q    <= '{default: '0};
         sum_q   <= '0;
         out_q   <= '0;
         idx_q   <= '0;
         cnt_q   <= '0;
         ack_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         ex_q    <= ex_d;
         sum_q   <= sum_d;
         out_q   <= out_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         ack_q   <= ack_d;
      end
   end

   assign outputs = out_q;
   assign ackSoft = ack_q;
endmodule

// File: tb/tb_softmax_1.sv
// Scoreboard bench for softmax_1: expected softmax values are queued at start
// of each run and compared once ackSoft rises.
`timescale 1ns/1ps
module tb_softmax_1;
   localparam int unsigned N = 10;

   logic            clk = 1'b0;
   logic            reset;
   logic            enable;
   logic [32*N-1:0] inputs;
   logic [32*N-1:0] outputs;
   logic            ackSoft;

   int unsigned n_vec = 0;
   int unsigned n_bad = 0;
   real         sb_q[$];
   real         last_want[N];
   real         cur[N];
   real         vec_a[N] = '{0.2, -0.2, 1.2, 1.3, -0.9, 0.3, 3.1, -0.02, 1.11, 0.323};
   real         vec_b[N] = '{0.69, -0.2, 1.2, 1.3, -0.9, 0.3, 3.1, -0.02, 1.11, 0.323};

   softmax_1 #(.DATA_WIDTH(32), .inputNum(10), .EXP_TERMS(16)) dut (
      .clk     (clk),
      .reset   (reset),
      .inputs  (inputs),
      .enable  (enable),
      .outputs (outputs),
      .ackSoft (ackSoft)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] f2b(input real r);
      logic [63:0] d;
      logic [23:0] m;
      int          e;
      if (r == 0.0) return '0;
      d = $realtobits(r);
      e = int'(d[62:52]) - 1023 + 127;
      m = {1'b0, d[51:29]};
      if (d[28] && ((|d[27:0]) || d[29])) m = m + 24'd1;
      if (m[23]) e = e + 1;
      return {d[63], e[7:0], m[22:0]};
   endfunction

   function automatic real b2r(input logic [31:0] f);
      logic [63:0] d;
      int          e;
      if (f[30:23] == 8'd0) return 0.0;
      e = int'(f[30:23]) - 127 + 1023;
      d = {f[31], e[10:0], f[22:0], 29'd0};
      return $bitstoreal(d);
   endfunction

   function automatic logic [31:0] el(input logic [32*N-1:0] v, input int i);
      return v[32*(N-i)-1 -: 32];
   endfunction

   function automatic real tol_of(input real want);
      return (want * 0.005 > 1e-4) ? want * 0.005 : 1e-4;
   endfunction

   task automatic check(input string tag, input real got, input real want, input real tol);
      n_vec++;
      if (got > want + tol || got < want - tol) begin
         n_bad++;
         $display("FAIL %s: got %g expected %g (tol %g)", tag, got, want, tol);
      end
   endtask

   task automatic push_expected();
      real xs[N];
      real s;
      s = 0.0;
      for (int i = 0; i < N; i++) begin
         xs[i] = b2r(f2b(cur[i]));
         s = s + $exp(xs[i]);
      end
      for (int i = 0; i < N; i++) sb_q.push_back($exp(xs[i]) / s);
   endtask

   task automatic drop_expected();
      for (int i = 0; i < N; i++)
         if (sb_q.size() > 0) void'(sb_q.pop_front());
   endtask

   task automatic start_run();
      @(negedge clk);
      enable = 1'b0;
      @(negedge clk);
      check("ack_low", real'(ackSoft), 0.0, 0.0);
      for (int i = 0; i < N; i++) inputs[32*(N-i)-1 -: 32] = f2b(cur[i]);
      push_expected();
      enable = 1'b1;
   endtask

   // pre = rising edges already elapsed since the edge that sampled enable
   task automatic finish_run(input int pre);
      int  edges;
      real got, want, sum;
      edges = pre - 1;
      do begin
         @(posedge clk);
         edges++;
         @(negedge clk);
      end while (!ackSoft && edges < 400);
      check("latency", real'(edges), 171.0, 0.0);
      if (sb_q.size() < N) begin
         check("sb_depth", real'(sb_q.size()), real'(N), 0.0);
      end else begin
         sum = 0.0;
         for (int i = 0; i < N; i++) begin
            want = sb_q.pop_front();
            got  = b2r(el(outputs, i));
            check($sformatf("out%0d", i), got, want, tol_of(want));
            sum = sum + got;
            last_want[i] = want;
         end
         check("sum", sum, 1.0, 1e-3);
      end
      repeat (20) @(negedge clk);
      check("ack_hold", real'(ackSoft), 1.0, 0.0);
      check("hold_out6", b2r(el(outputs, 6)), last_want[6], tol_of(last_want[6]));
   endtask

   initial begin
      reset  = 1'b0;
      enable = 1'b0;
      inputs = '0;
      #1;
      check("rst_ack", real'(ackSoft), 0.0, 0.0);
      check("rst_out", (outputs == '0) ? 0.0 : 1.0, 0.0, 0.0);
      repeat (3) @(negedge clk);
      reset = 1'b1;

      cur = vec_a; start_run(); finish_run(0);
      cur = vec_b; start_run(); finish_run(0);

      for (int i = 0; i < N; i++) cur[i] = 0.0;
      start_run(); finish_run(0);
      for (int i = 0; i < N; i++)
         check("zero_ulp", real'(el(outputs, i)), real'(32'h3DCCCCCD), 1.0);

      // abort at cycle 50, previous results must survive
      cur = vec_a; start_run();
      repeat (50) @(negedge clk);
      enable = 1'b0;
      repeat (5) begin
         @(negedge clk);
         check("abort_ack", real'(ackSoft), 0.0, 0.0);
      end
      for (int i = 0; i < N; i++)
         check("abort_keep", b2r(el(outputs, i)), last_want[i], 1e-4);
      drop_expected();
      cur = vec_b; start_run(); finish_run(0);

      // inputs altered mid-EXP must not affect the run
      cur = vec_a; start_run();
      repeat (20) @(negedge clk);
      for (int i = 0; i < N; i++) inputs[32*(N-i)-1 -: 32] = f2b(2.0 - 0.3 * i);
      finish_run(20);

      // asynchronous reset during EXP, then restart with enable held high
      cur = vec_b; start_run();
      repeat (40) @(negedge clk);
      reset = 1'b0;
      #1;
      check("rst_mid_ack", real'(ackSoft), 0.0, 0.0);
      check("rst_mid_out", (outputs == '0) ? 0.0 : 1.0, 0.0, 0.0);
      drop_expected();
      @(negedge clk);
      reset = 1'b1;
      push_expected();
      finish_run(0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
